// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the MEM stage of the pipelined core. It accepts
// one load or store at a time over a valid/ready handshake, waits a fixed
// access latency, then returns a single-cycle response. While an access is
// outstanding it raises stall so the pipeline holds.
//
// Parameters
//   ADDR_W   word-address bits; the array holds 2**ADDR_W 32-bit words
//   LATENCY  WAIT cycles between accept and response (1..15)
//
// Ports
//   clk         single clock, rising-edge
//   rst         asynchronous active-low reset
//   req_valid   request present (held with stable fields until resp_valid)
//   req_ready   responder idle and able to accept
//   req_we      1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data
//   req_be      store byte enables, bit i covers [8i+7:8i]
//   resp_valid  one-cycle response pulse
//   resp_rdata  load data (0 for stores and errors), registered
//   resp_err    misaligned / out-of-range flag, registered
//   stall       pipeline hold request
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int          LP_DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  LP_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_err;

    logic [31:0]         r_rdata;
    logic                r_resp_err;

    logic [31:0]         r_mem [0:LP_DEPTH-1];

    logic                w_accept;
    logic                w_access;
    logic                w_err;

    // Any address bit above the word index makes the request out of range.
    assign w_err    = (req_addr[1:0] != 2'b00) ||
                      ((req_addr >> (ADDR_W + 2)) != 32'd0);

    assign w_accept = (r_state == S_IDLE) && req_valid;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                // Never accept here: the MEM stage is still holding the
                // request that just completed.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, counter, captured request and registered response
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_resp_err <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_we    <= req_we;
                r_idx   <= req_addr[ADDR_W+1:2];
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_err   <= w_err;
                r_cnt   <= LP_CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                if (r_err) begin
                    r_rdata    <= '0;
                    r_resp_err <= 1'b1;
                end else if (r_we) begin
                    r_rdata    <= '0;
                    r_resp_err <= 1'b0;
                end else begin
                    r_rdata    <= r_mem[r_idx];
                    r_resp_err <= 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Memory array: not reset. A reset during WAIT forces r_state to IDLE
    // asynchronously, so a store that has not reached its write edge is
    // dropped without needing rst in this process.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_access && r_we && !r_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_resp_err;
    assign stall      = req_valid & ~resp_valid;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core's MEM stage. It accepts one load or store request at a time over a valid/ready handshake, waits a fixed access latency, then returns a one-cycle response. While an access is outstanding it drives a stall to the pipeline. It replaces the single-cycle data memory so the core can be run against slower memory timing.

## Interface

Parameters:
- ADDR_W, 8: word-address bits; the array holds 2^ADDR_W 32-bit words.
- LATENCY, 2: WAIT cycles between accept and response. Legal range is 1..15.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request. Held with stable fields until resp_valid is seen.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit i covers bits [8i+7:8i].
- resp_valid  out  1  response pulse, exactly one cycle.
- resp_rdata  out  32  load data. 0 for stores and for errors.
- resp_err  out  1  request was misaligned or out of range. Valid with resp_valid.
- stall  out  1  pipeline hold request.

## Operation

- States: IDLE, WAIT, RESP. Reset state is IDLE.
- req_ready = (state == IDLE). It is combinational from state only.
- IDLE:
  - On req_valid, capture we, addr, wdata and be.
  - Compute err = (addr[1:0] != 0) or (addr[31:ADDR_W+2] != 0).
  - Load cnt = LATENCY-1 and go to WAIT.
- WAIT:
  - If cnt != 0, decrement cnt and stay in WAIT.
  - If cnt == 0, perform the access at this edge and go to RESP.
  - Store, no error: for each i with be[i] = 1, write byte lane i of mem[addr[ADDR_W+1:2]]. Lanes with be[i] = 0 are unchanged. resp_rdata <= 0.
  - Load, no error: resp_rdata <= mem[addr[ADDR_W+1:2]].
  - Error: no array write; resp_rdata <= 0; resp_err <= 1.
- RESP:
  - resp_valid = 1 for this cycle, then go to IDLE unconditionally.
  - Requests are not accepted in RESP. This prevents the still-held request from being re-accepted.
- stall = req_valid & ~resp_valid.
  - Stall is therefore high in the IDLE accept cycle and through all WAIT cycles.
  - Stall is low in the RESP cycle, so the MEM stage advances on that edge.
- Request fields are ignored outside IDLE. The captured copies are used.
- The memory array is not reset. Contents are undefined until written. Reset does not alter the array.

## Timing

- A request present in cycle t (state IDLE) is accepted at the end of t.
- WAIT occupies cycles t+1 .. t+LATENCY.
- resp_valid is high in cycle t+LATENCY+1.
- The earliest next accept is cycle t+LATENCY+2. Throughput is one access per LATENCY+2 cycles.
- LATENCY = 1 gives a single WAIT cycle with cnt = 0.
- Reset values: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, stall = req_valid.
- resp_rdata and resp_err are registered. They hold their values until the next access completes.
- Reset asserted mid-access (in WAIT or RESP):
  - Go to IDLE immediately and clear the registered outputs.
  - A pending store that has not reached its write edge is dropped.
  - A store whose write edge has already occurred persists.
- req_valid dropping while in WAIT is a protocol violation. The access still completes and the response is still issued.

## Test plan

- Store then load, LATENCY=2: store 0xDEADBEEF, be=4'hF, to addr 0x10, then load addr 0x10. Each resp_valid comes 3 cycles after accept. The load returns 0xDEADBEEF with err=0.
- Byte enables: word 0x11223344 at 0x20, then store 0xAABBCCDD with be=4'b0101, then load. Load returns 0x11BB33DD.
- Misaligned: load from 0x22. Response shows resp_err=1, resp_rdata=0. Store to 0x22 with be=4'hF leaves mem[8] unchanged.
- Out of range, ADDR_W=8: store to 0x400. resp_err=1 and no write occurs; mem[0] is unchanged.
- Handshake and stall: hold req_valid continuously across two back-to-back requests. Check:
  - req_ready is low in WAIT and RESP.
  - stall is high for LATENCY+1 cycles per request and low in the RESP cycle.
  - Exactly one resp_valid pulse per request.
  - Second accept occurs exactly LATENCY+2 cycles after the first.
- Reset mid-WAIT: assert rst in the first WAIT cycle of a store. Outputs return to reset values immediately and the state is IDLE. A subsequent load of that address returns the pre-store value.
